// File: rtl/jtdd_snd_level.sv
// jtdd_snd_level -- output level stage after jtdd_sound.
//
// Takes the mono signed sample stream and its strobe, removes DC with a
// leaky integrator, applies a ramped fx-level gain (Q1.6, 64 = unity) and
// saturates the result back to DW bits. Three-stage pipeline, one sample
// per clock sustained, sample_out = sample_in delayed by 3 clk.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active high
//   snd_in      signed input sample, valid while sample_in=1
//   sample_in   one-clock input strobe
//   fxlevel     target gain select: 0=32, 1=48, 2=64, 3=96
//   mute        forces the gain target to 0
//   dc_en       1 = DC removal active, 0 = DC stage bypassed
//   snd_out     signed processed sample, held between strobes
//   sample_out  one-clock strobe, snd_out updated in this cycle
//   clip        high with sample_out when that sample saturated
module jtdd_snd_level #(
  parameter int DW   = 16,
  parameter int DCSH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] snd_in,
  input  logic                 sample_in,
  input  logic [1:0]           fxlevel,
  input  logic                 mute,
  input  logic                 dc_en,
  output logic signed [DW-1:0] snd_out,
  output logic                 sample_out,
  output logic                 clip
);
  localparam int AW = DW + DCSH;  // DC accumulator width
  localparam int PW = DW + 9;     // product width: (DW+1) x 8 signed

  // ---------------- gain ramp ----------------
  logic [6:0] gain_q, gain_d, target;

  always_comb begin
    case (fxlevel)
      2'd0:    target = 7'd32;
      2'd1:    target = 7'd48;
      2'd2:    target = 7'd64;
      default: target = 7'd96;
    endcase
    if (mute) target = 7'd0;
  end

  // One step per strobe toward the target; a target change simply
  // redirects the next step, so the gain never jumps.
  always_comb begin
    gain_d = gain_q;
    if (sample_in) begin
      if (gain_q < target)      gain_d = gain_q + 7'd1;
      else if (gain_q > target) gain_d = gain_q - 7'd1;
    end
  end

  // ---------------- S1: DC removal ----------------
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW:0]   x_ext, dc_ext, diff, y1_d;
  logic signed [DW:0]   y1_q;
  logic [6:0]           g1_q;

  // acc >>> DCSH truncated to DW bits is exactly the top DW bits of acc.
  assign x_ext  = {snd_in[DW-1], snd_in};
  assign dc_ext = {acc_q[AW-1], acc_q[AW-1:DCSH]};
  assign diff   = x_ext - dc_ext;
  assign y1_d   = dc_en ? diff : x_ext;

  always_comb begin
    acc_d = acc_q;
    if (sample_in && dc_en) acc_d = acc_q + {{(DCSH-1){diff[DW]}}, diff};
  end

  // ---------------- S2: gain multiply ----------------
  logic signed [PW-1:0] ya, ga, p_q;
  assign ya = {{(PW-DW-1){y1_q[DW]}}, y1_q};
  assign ga = {{(PW-7){1'b0}}, g1_q};

  // ---------------- S3: scale and saturate ----------------
  logic signed [PW-1:0] q_full;
  logic                 ovf;
  logic signed [DW-1:0] sat_val, s3_d;

  // Arithmetic shift floors toward -inf. Overflow when the bits from the
  // DW-1 sign position upward are not all equal.
  assign q_full  = p_q >>> 6;
  assign ovf     = !((&q_full[PW-1:DW-1]) || (~|q_full[PW-1:DW-1]));
  assign sat_val = q_full[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  assign s3_d    = ovf ? sat_val : q_full[DW-1:0];

  // ---------------- registers ----------------
  logic [2:0]           vld_pipe_q;
  logic signed [DW-1:0] snd_out_q;
  logic                 clip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_q     <= '0;
      acc_q      <= '0;
      y1_q       <= '0;
      g1_q       <= '0;
      p_q        <= '0;
      snd_out_q  <= '0;
      clip_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      gain_q     <= gain_d;
      acc_q      <= acc_d;
      vld_pipe_q <= {vld_pipe_q[1:0], sample_in};
      // S1 captures the gain before this strobe's ramp step
      y1_q       <= y1_d;
      g1_q       <= gain_q;
      p_q        <= ya * ga;
      if (vld_pipe_q[1]) snd_out_q <= s3_d;
      clip_q     <= vld_pipe_q[1] & ovf;
    end
  end

  assign snd_out    = snd_out_q;
  assign sample_out = vld_pipe_q[2];
  assign clip       = clip_q;

endmodule

// File: tb/tb_jtdd_snd_level.sv
// Directed bench for jtdd_snd_level (DW=16, DCSH=4).
module tb_jtdd_snd_level;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] snd_in = '0;
  logic               sample_in = 1'b0;
  logic [1:0]         fxlevel = 2'd2;
  logic               mute = 1'b0;
  logic               dc_en = 1'b0;
  logic signed [15:0] snd_out;
  logic               sample_out;
  logic               clip;

  int vectors = 0;
  int miscompares = 0;

  jtdd_snd_level #(.DW(16), .DCSH(4)) dut (
    .clk(clk), .rst(rst), .snd_in(snd_in), .sample_in(sample_in),
    .fxlevel(fxlevel), .mute(mute), .dc_en(dc_en),
    .snd_out(snd_out), .sample_out(sample_out), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    sample_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // n strobes on consecutive cycles with a constant sample
  task automatic run_strobes(input int n, input logic signed [15:0] x);
    @(posedge clk); #1;
    snd_in = x; sample_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 sample_in = 1'b0;
  endtask

  // one strobe, then sample the outputs in the sample_out cycle (3 clk later)
  task automatic xfer(input logic signed [15:0] x, output logic signed [15:0] y,
                      output logic so, output logic c);
    @(posedge clk); #1;
    snd_in = x; sample_in = 1'b1;
    @(posedge clk); #1;
    sample_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    y = snd_out; so = sample_out; c = clip;
  endtask

  task automatic test_reset();
    logic signed [15:0] y; logic so, c;
    do_reset();
    vectors++; if (snd_out !== 16'h0000) begin miscompares++; $display("FAIL rst_snd_out got %h want 0000", snd_out); end
    vectors++; if (sample_out !== 1'b0) begin miscompares++; $display("FAIL rst_sample_out got %b want 0", sample_out); end
    vectors++; if (clip !== 1'b0) begin miscompares++; $display("FAIL rst_clip got %b want 0", clip); end
    xfer(16'sh1000, y, so, c);
    vectors++; if (so !== 1'b1) begin miscompares++; $display("FAIL first_strobe_out got %b want 1", so); end
    vectors++; if (y !== 16'h0000) begin miscompares++; $display("FAIL first_gain0 got %h want 0000", y); end
    vectors++; if (c !== 1'b0) begin miscompares++; $display("FAIL first_clip got %b want 0", c); end
  endtask

  task automatic test_unity();
    logic signed [15:0] y; logic so, c;
    do_reset();
    fxlevel = 2'd2; dc_en = 1'b0;
    run_strobes(63, 16'sh0000);
    xfer(16'sh1000, y, so, c);  // gain 63
    vectors++; if (y !== 16'h0FC0) begin miscompares++; $display("FAIL gain63 got %h want 0fc0", y); end
    xfer(16'sh1000, y, so, c);  // gain 64
    vectors++; if (y !== 16'h1000) begin miscompares++; $display("FAIL unity got %h want 1000", y); end
    vectors++; if (so !== 1'b1) begin miscompares++; $display("FAIL unity_strobe got %b want 1", so); end
    vectors++; if (c !== 1'b0) begin miscompares++; $display("FAIL unity_clip got %b want 0", c); end
    repeat (2) @(posedge clk); #1;
    vectors++; if (sample_out !== 1'b0) begin miscompares++; $display("FAIL idle_strobe got %b want 0", sample_out); end
    vectors++; if (snd_out !== 16'h1000) begin miscompares++; $display("FAIL idle_hold got %h want 1000", snd_out); end
    vectors++; if (clip !== 1'b0) begin miscompares++; $display("FAIL idle_clip got %b want 0", clip); end
  endtask

  task automatic test_ramp_up();
    logic signed [15:0] y; logic so, c;
    fxlevel = 2'd3;
    run_strobes(16, 16'sh0000);  // 64 -> 80
    xfer(16'sh1000, y, so, c);
    vectors++; if (y !== 16'h1400) begin miscompares++; $display("FAIL ramp80 got %h want 1400", y); end
    run_strobes(14, 16'sh0000);  // 81 -> 95
    xfer(16'sh1000, y, so, c);
    vectors++; if (y !== 16'h17C0) begin miscompares++; $display("FAIL ramp95 got %h want 17c0", y); end
    xfer(16'sh1000, y, so, c);
    vectors++; if (y !== 16'h1800) begin miscompares++; $display("FAIL ramp96 got %h want 1800", y); end
    xfer(16'sh1000, y, so, c);
    vectors++; if (y !== 16'h1800) begin miscompares++; $display("FAIL ramp96_hold got %h want 1800", y); end
  endtask

  task automatic test_saturate();
    logic signed [15:0] y; logic so, c;
    xfer(16'sh7000, y, so, c);
    vectors++; if (y !== 16'h7FFF || c !== 1'b1) begin miscompares++; $display("FAIL sat_pos got %h/%b want 7fff/1", y, c); end
    xfer(-16'sh7000, y, so, c);
    vectors++; if (y !== 16'h8000 || c !== 1'b1) begin miscompares++; $display("FAIL sat_neg got %h/%b want 8000/1", y, c); end
    xfer(-16'sh0001, y, so, c);
    vectors++; if (y !== 16'hFFFE || c !== 1'b0) begin miscompares++; $display("FAIL floor_m1 got %h/%b want fffe/0", y, c); end
    xfer(16'sh5555, y, so, c);  // 32767.5 floors to max, no clip
    vectors++; if (y !== 16'h7FFF || c !== 1'b0) begin miscompares++; $display("FAIL edge_5555 got %h/%b want 7fff/0", y, c); end
    xfer(16'sh5556, y, so, c);  // 32769 -> clipped
    vectors++; if (y !== 16'h7FFF || c !== 1'b1) begin miscompares++; $display("FAIL edge_5556 got %h/%b want 7fff/1", y, c); end
  endtask

  task automatic test_mute();
    logic signed [15:0] y; logic so, c;
    mute = 1'b1;
    xfer(16'sh1000, y, so, c);  // g1=96, gain -> 95
    vectors++; if (y !== 16'h1800) begin miscompares++; $display("FAIL mute_g96 got %h want 1800", y); end
    xfer(16'sh1000, y, so, c);  // g1=95, gain -> 94
    vectors++; if (y !== 16'h17C0) begin miscompares++; $display("FAIL mute_g95 got %h want 17c0", y); end
    mute = 1'b0;
    xfer(16'sh1000, y, so, c);  // g1=94, redirected up
    vectors++; if (y !== 16'h1780) begin miscompares++; $display("FAIL unmute_g94 got %h want 1780", y); end
    xfer(16'sh1000, y, so, c);
    vectors++; if (y !== 16'h17C0) begin miscompares++; $display("FAIL unmute_g95 got %h want 17c0", y); end
  endtask

  task automatic test_dc();
    logic signed [15:0] y, y1; logic so, c;
    do_reset();
    fxlevel = 2'd2; dc_en = 1'b0;
    run_strobes(64, 16'sh0000);
    dc_en = 1'b1;
    run_strobes(199, 16'sh0400);
    xfer(16'sh0400, y, so, c);
    vectors++; if (y > 16'sd16 || y < -16'sd16) begin miscompares++; $display("FAIL dc_settle got %0d want |y|<=16", y); end
    xfer(16'sh0000, y, so, c);
    vectors++; if (y > -16'sd1008 || y < -16'sd1040) begin miscompares++; $display("FAIL dc_step got %0d want about -1024", y); end
    y1 = y;
    xfer(16'sh0000, y, so, c);
    vectors++; if (!(y < 0 && y > y1)) begin miscompares++; $display("FAIL dc_decay got %0d want in (%0d,0)", y, y1); end
    dc_en = 1'b0;
    xfer(16'sh0123, y, so, c);
    vectors++; if (y !== 16'h0123) begin miscompares++; $display("FAIL dc_bypass got %h want 0123", y); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] y; logic so, c;
    logic signed [15:0] exp_v [3];
    exp_v[0] = 16'sh0100; exp_v[1] = 16'sh0200; exp_v[2] = 16'sh0300;
    @(posedge clk); #1;
    sample_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      snd_in = exp_v[i];
      @(posedge clk); #1;
    end
    sample_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (sample_out !== 1'b1 || snd_out !== exp_v[i]) begin
        miscompares++; $display("FAIL b2b_%0d got %b/%h want 1/%h", i, sample_out, snd_out, exp_v[i]);
      end
      @(posedge clk); #1;
    end
    vectors++; if (sample_out !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", sample_out); end
    // reset in the middle of a burst
    @(posedge clk); #1;
    snd_in = 16'sh0400; sample_in = 1'b1;
    @(posedge clk); #1;
    snd_in = 16'sh0500;
    @(posedge clk); #1;
    rst = 1'b1; sample_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (sample_out !== 1'b0 || snd_out !== 16'h0000 || clip !== 1'b0) begin
        miscompares++; $display("FAIL rst_burst_%0d got %b/%h/%b want 0/0000/0", i, sample_out, snd_out, clip);
      end
    end
    rst = 1'b0;
    xfer(16'sh1000, y, so, c);
    vectors++; if (so !== 1'b1 || y !== 16'h0000) begin miscompares++; $display("FAIL ramp_restart got %b/%h want 1/0000", so, y); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_ramp_up();
    test_saturate();
    test_mute();
    test_dc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
